// File: rtl/fetch_stage_prefetch_if.sv
// Bus bundle between the fetch stage and its environment: memory read port,
// store-stage redirect port and decode port.
interface fetch_stage_prefetch_if #(
  parameter int ADDR_W         = 64,
  parameter int INSN_W         = 32,
  parameter int INSNS_PER_LINE = 2,
  parameter int MASK_W         = 64,
  parameter int BUSID_W        = 8
);
  logic                             mem_req_valid;
  logic                             mem_req_ready;
  logic [ADDR_W-1:0]                mem_req_addr;
  logic [BUSID_W-1:0]               mem_req_id;
  logic                             mem_rsp_valid;
  logic [BUSID_W-1:0]               mem_rsp_id;
  logic [INSN_W*INSNS_PER_LINE-1:0] mem_rsp_data;
  logic                             redir_valid;
  logic                             redir_ready;
  logic [ADDR_W-1:0]                redir_pc;
  logic [MASK_W-1:0]                redir_mask;
  logic                             dec_valid;
  logic                             dec_ready;
  logic [ADDR_W-1:0]                dec_pc;
  logic [INSN_W-1:0]                dec_insn;
  logic [MASK_W-1:0]                dec_mask;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_id, redir_ready,
           dec_valid, dec_pc, dec_insn, dec_mask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_id, mem_rsp_data,
           redir_valid, redir_pc, redir_mask, dec_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_id, redir_ready,
           dec_valid, dec_pc, dec_insn, dec_mask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_id, mem_rsp_data,
           redir_valid, redir_pc, redir_mask, dec_ready
  );
endinterface

// File: rtl/fetch_stage_prefetch.sv
// Instruction fetch stage with a DEPTH-line prefetch buffer; a one-bit epoch
// in the bus id lets responses in flight across a redirect be discarded.
module fetch_stage_prefetch #(
  parameter int                CORE_ID        = 0,
  parameter int                ADDR_W         = 64,
  parameter int                INSN_W         = 32,
  parameter int                INSNS_PER_LINE = 2,
  parameter int                DEPTH          = 4,
  parameter int                MASK_W         = 64,
  parameter int                BUSID_W        = 8,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_stage_prefetch_if.master bus,
  output logic [31:0]           stall_cycles
);
  localparam int IB     = INSN_W / 8;
  localparam int LB     = IB * INSNS_PER_LINE;
  localparam int LINE_W = INSN_W * INSNS_PER_LINE;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SLOT_W = (INSNS_PER_LINE > 1) ? $clog2(INSNS_PER_LINE) : 1;
  localparam int NCF    = 9;
  // HALT, JMP_ALWAYS, JMP_EQUAL, JMP_NOT_EQUAL, JMP_GREATER, JMP_GREATER_EQUAL,
  // JMP_LOWER, JMP_LOWER_EQUAL, LOAD_RESTORE_PC
  localparam logic [NCF*8-1:0] CF_OPS = {8'hFF, 8'h20, 8'h21, 8'h22, 8'h23,
                                         8'h24, 8'h25, 8'h26, 8'h30};
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LB - 1);

  typedef enum logic {RUN, WAIT_REDIR} state_t;

  state_t              state_reg;
  logic                active_reg;
  logic [ADDR_W-1:0]   fetch_pc_reg;
  logic [ADDR_W-1:0]   req_pc_reg;
  logic [MASK_W-1:0]   mask_reg;
  logic                epoch_reg;
  logic [CNT_W-1:0]    outstanding_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [31:0]         stall_reg;
  logic [LINE_W-1:0]   line_mem [DEPTH];

  logic [ADDR_W-1:0]   slot_full;
  logic [SLOT_W-1:0]   slot;
  logic                last_slot;
  logic [INSN_W-1:0]   head_slots [INSNS_PER_LINE];
  logic [INSN_W-1:0]   head_insn;
  logic [NCF-1:0]      cf_hit;
  logic [CNT_W:0]      credit_used;
  logic                dec_valid;
  logic                req_fire, rsp_dec, rsp_push, dec_fire, pop, redir_fire;
  logic                rsp_id_unused;

  // The head line's slot always follows fetch_pc, so a line entered mid-way
  // after a redirect starts at the right instruction without extra state.
  assign slot_full = (fetch_pc_reg / ADDR_W'(IB)) % ADDR_W'(INSNS_PER_LINE);
  assign slot      = SLOT_W'(slot_full);
  assign last_slot = (slot_full == ADDR_W'(INSNS_PER_LINE - 1));

  for (genvar gi = 0; gi < INSNS_PER_LINE; gi++) begin : g_slot
    assign head_slots[gi] = line_mem[rd_ptr_reg][gi*INSN_W +: INSN_W];
  end
  assign head_insn = head_slots[slot];

  for (genvar gi = 0; gi < NCF; gi++) begin : g_cf
    assign cf_hit[gi] = (head_insn[7:0] == CF_OPS[gi*8 +: 8]);
  end

  assign credit_used = {1'b0, outstanding_reg} + {1'b0, count_reg};
  assign dec_valid   = (state_reg == RUN) && (count_reg != '0);

  assign bus.mem_req_valid = active_reg && (state_reg == RUN) &&
                             (credit_used < (CNT_W+1)'(DEPTH));
  assign bus.mem_req_addr  = req_pc_reg;
  assign bus.mem_req_id    = {(BUSID_W-1)'(CORE_ID), epoch_reg};
  assign bus.redir_ready   = (state_reg == WAIT_REDIR);
  assign bus.dec_valid     = dec_valid;
  assign bus.dec_pc        = fetch_pc_reg;
  assign bus.dec_insn      = head_insn;
  assign bus.dec_mask      = mask_reg;
  assign stall_cycles      = stall_reg;
  assign rsp_id_unused     = ^bus.mem_rsp_id[BUSID_W-1:1];

  assign req_fire   = bus.mem_req_valid && bus.mem_req_ready;
  assign redir_fire = (state_reg == WAIT_REDIR) && bus.redir_valid;
  // A late response must not wrap the counter after reset cleared it.
  assign rsp_dec    = bus.mem_rsp_valid && (outstanding_reg != '0);
  assign rsp_push   = bus.mem_rsp_valid && (bus.mem_rsp_id[0] == epoch_reg) && !redir_fire;
  assign dec_fire   = dec_valid && bus.dec_ready;
  assign pop        = dec_fire && last_slot;

  always_ff @(posedge clk) begin
    if (rsp_push) begin
      line_mem[wr_ptr_reg] <= bus.mem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= RUN;
      active_reg      <= 1'b0;
      fetch_pc_reg    <= RESET_PC;
      req_pc_reg      <= RESET_PC & LINE_MASK;
      mask_reg        <= '1;
      epoch_reg       <= 1'b0;
      outstanding_reg <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      stall_reg       <= '0;
    end else begin
      active_reg      <= 1'b1;
      outstanding_reg <= outstanding_reg + CNT_W'(req_fire) - CNT_W'(rsp_dec);
      if (req_fire) begin
        req_pc_reg <= req_pc_reg + ADDR_W'(LB);
      end
      if ((state_reg == RUN) && !dec_valid && (stall_reg != '1)) begin
        stall_reg <= stall_reg + 32'd1;
      end
      if (redir_fire) begin
        count_reg  <= '0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        count_reg <= count_reg + CNT_W'(rsp_push) - CNT_W'(pop);
        if (rsp_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)      rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case (state_reg)
        RUN: begin
          if (dec_fire) begin
            fetch_pc_reg <= fetch_pc_reg + ADDR_W'(IB);
            if (|cf_hit) state_reg <= WAIT_REDIR;
          end
        end
        WAIT_REDIR: begin
          if (redir_fire) begin
            state_reg    <= RUN;
            fetch_pc_reg <= bus.redir_pc;
            req_pc_reg   <= bus.redir_pc & LINE_MASK;
            mask_reg     <= bus.redir_mask;
            epoch_reg    <= ~epoch_reg;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage_prefetch.sv
// Directed bench for fetch_stage_prefetch: an in-order memory model, a
// program-order decode model and a per-cycle compare on the falling edge.
module tb_fetch_stage_prefetch;
  localparam int ADDR_W = 64, INSN_W = 32, IPL = 2, DEPTH = 4;
  localparam int MASK_W = 64, BUSID_W = 8, CORE_ID = 0;
  localparam logic [7:0] OP_ADD = 8'h01, OP_HALT = 8'hFF, OP_JMP = 8'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  fetch_stage_prefetch_if #(.ADDR_W(ADDR_W), .INSN_W(INSN_W), .INSNS_PER_LINE(IPL),
                            .MASK_W(MASK_W), .BUSID_W(BUSID_W)) bus ();

  fetch_stage_prefetch #(.CORE_ID(CORE_ID), .ADDR_W(ADDR_W), .INSN_W(INSN_W),
                         .INSNS_PER_LINE(IPL), .DEPTH(DEPTH), .MASK_W(MASK_W),
                         .BUSID_W(BUSID_W), .RESET_PC('0)) dut (
    .clk(clk), .reset(reset), .bus(bus), .stall_cycles(stall_cycles));

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Program image: every word is ADD unless overridden; upper bits tag the address.
  logic [7:0] prog [logic [63:0]];

  function automatic logic [31:0] word_at(input logic [63:0] a);
    logic [7:0] op;
    op = prog.exists(a) ? prog[a] : OP_ADD;
    return {a[25:2], op};
  endfunction

  function automatic logic [31:0] insn_at_pc(input logic [63:0] pc);
    return word_at((pc & ~64'h7) + {61'b0, pc[2], 2'b00});
  endfunction

  function automatic bit is_cf(input logic [7:0] op);
    return (op == 8'hFF) || (op >= 8'h20 && op <= 8'h26) || (op == 8'h30);
  endfunction

  typedef struct { logic [63:0] addr; logic [7:0] id; int due; bit late; } mreq_t;
  typedef struct { logic [63:0] pc; int cyc; logic [63:0] mask; logic [31:0] insn; } dlog_t;
  mreq_t       mq[$];
  dlog_t       dlog[$];
  logic [63:0] rlog[$];
  int          mem_lat = 1;
  int          cyc = 0;
  bit          rsp_late_cur = 0;

  // In-order memory: answers each accepted request mem_lat cycles later.
  initial begin
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_id    = '0;
    bus.mem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_id    = mq[0].id;
        bus.mem_rsp_data  = {word_at(mq[0].addr + 64'd4), word_at(mq[0].addr)};
        rsp_late_cur      = mq[0].late;
        void'(mq.pop_front());
      end else begin
        bus.mem_rsp_valid = 1'b0;
      end
    end
  end

  // Reference state in architectural terms.
  logic [63:0] exp_pc = 0, exp_mask = '1, exp_req_addr = 0;
  bit          exp_wait = 0, exp_epoch = 0, prev_reset = 1, held = 0;
  int          exp_stall = 0, bench_out = 0;

  always @(negedge clk) begin
    if (prev_reset) begin
      check("rst_dec_valid", bus.dec_valid, 0);
      check("rst_req_valid", bus.mem_req_valid, 0);
      check("rst_redir_ready", bus.redir_ready, 0);
      check("rst_stall", stall_cycles, 0);
      check("rst_dec_pc", bus.dec_pc, 0);
    end else begin
      check("redir_ready", bus.redir_ready, exp_wait);
      if (exp_wait) begin
        check("wait_dec_valid", bus.dec_valid, 0);
        check("wait_req_valid", bus.mem_req_valid, 0);
      end
      if (held) check("held_dec_valid", bus.dec_valid, 1);
      if (bus.dec_valid) begin
        check("dec_pc", bus.dec_pc, exp_pc);
        check("dec_insn", bus.dec_insn, insn_at_pc(exp_pc));
        check("dec_mask", bus.dec_mask, exp_mask);
      end
      if (bus.mem_req_valid) begin
        check("req_addr", bus.mem_req_addr, exp_req_addr);
        check("req_id", bus.mem_req_id, {7'(CORE_ID), exp_epoch});
      end
      check("stall", stall_cycles, exp_stall);
      check("credit", bench_out <= DEPTH, 1);
    end

    prev_reset = reset;
    if (reset) begin
      exp_pc = 0; exp_mask = '1; exp_req_addr = 0; exp_wait = 0; exp_epoch = 0;
      exp_stall = 0; bench_out = 0; held = 0;
      foreach (mq[i]) mq[i].late = 1;
    end else begin
      if (bus.mem_rsp_valid && !rsp_late_cur && bench_out > 0) bench_out--;
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        mq.push_back('{bus.mem_req_addr, bus.mem_req_id, cyc + mem_lat, 1'b0});
        rlog.push_back(bus.mem_req_addr);
        bench_out++;
        exp_req_addr = exp_req_addr + 64'd8;
      end
      if (!exp_wait && !bus.dec_valid) exp_stall++;
      if (bus.dec_valid && bus.dec_ready) begin
        dlog.push_back('{bus.dec_pc, cyc, bus.dec_mask, bus.dec_insn});
        if (is_cf(insn_at_pc(exp_pc)) && !exp_wait) exp_wait = 1;
        exp_pc = exp_pc + 64'd4;
      end
      if (exp_wait && bus.redir_valid) begin
        exp_pc       = bus.redir_pc;
        exp_mask     = bus.redir_mask;
        exp_req_addr = bus.redir_pc & ~64'h7;
        exp_epoch    = ~exp_epoch;
        exp_wait     = 0;
      end
      held = bus.dec_valid && !bus.dec_ready;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  int          dmark, rmark, r0, r1;
  logic [63:0] p0, a0;
  logic [31:0] i0, s0;

  initial begin
    reset = 1'b1;
    bus.mem_req_ready = 1'b1;
    bus.dec_ready     = 1'b1;
    bus.redir_valid   = 1'b0;
    bus.redir_pc      = '0;
    bus.redir_mask    = '0;
    tick(3);
    reset = 1'b0;

    // 1: streaming ADD pairs from reset
    tick(20);
    check("t1_count", dlog.size() >= 3, 1);
    if (dlog.size() >= 3) begin
      check("t1_pc0", dlog[0].pc, 64'h0);
      check("t1_pc1", dlog[1].pc, 64'h4);
      check("t1_pc2", dlog[2].pc, 64'h8);
      check("t1_insn1", dlog[1].insn, 32'h0000_0101);
      check("t1_back2back", dlog[2].cyc - dlog[0].cyc, 2);
      check("t1_mask", dlog[0].mask, 64'hFFFF_FFFF_FFFF_FFFF);
    end

    // 2: JMP_ALWAYS at 0x8, redirect to unaligned 0x106
    prog[64'h8] = OP_JMP;
    pulse_reset();
    dlog.delete();
    rlog.delete();
    for (int i = 0; i < 50 && !bus.redir_ready; i++) tick(1);
    check("t2_reach_wait", bus.redir_ready, 1);
    tick(5);
    check("t2_delivered", dlog.size(), 3);
    check("t2_prefetched", rlog.size() >= 3, 1);
    rmark = rlog.size();
    dmark = dlog.size();
    bus.redir_pc    = 64'h106;
    bus.redir_mask  = 64'h0F;
    bus.redir_valid = 1'b1;
    tick(1);
    bus.redir_valid = 1'b0;
    tick(10);
    check("t2_post_count", dlog.size() > dmark && rlog.size() > rmark, 1);
    if (dlog.size() > dmark && rlog.size() > rmark) begin
      check("t2_pc", dlog[dmark].pc, 64'h106);
      check("t2_insn", dlog[dmark].insn, 32'h0000_4101);
      check("t2_mask", dlog[dmark].mask, 64'h0F);
      check("t2_req_addr", rlog[rmark], 64'h100);
    end

    // 3: decode back-pressure
    bus.dec_ready = 1'b0;
    check("t3_valid_at_stall", bus.dec_valid, 1);
    p0 = bus.dec_pc;
    i0 = bus.dec_insn;
    tick(5);
    r1 = rlog.size();
    tick(5);
    check("t3_pc_held", bus.dec_pc, p0);
    check("t3_insn_held", bus.dec_insn, i0);
    check("t3_no_more_req", rlog.size(), r1);
    check("t3_req_valid_low", bus.mem_req_valid, 0);
    bus.dec_ready = 1'b1;
    tick(3);

    // 4: memory back-pressure
    bus.mem_req_ready = 1'b0;
    tick(12);
    s0 = stall_cycles;
    a0 = bus.mem_req_addr;
    r0 = rlog.size();
    tick(20);
    check("t4_stall_delta", stall_cycles - s0, 20);
    check("t4_addr_stable", bus.mem_req_addr, a0);
    check("t4_req_valid_high", bus.mem_req_valid, 1);
    check("t4_no_dup_req", rlog.size(), r0);
    bus.mem_req_ready = 1'b1;

    // 5: reset with requests in flight under epoch 1
    mem_lat = 4;
    tick(10);
    reset = 1'b1;
    bus.mem_req_ready = 1'b0;
    tick(1);
    reset = 1'b0;
    check("t5_late_pending", mq.size() >= 1, 1);
    check("t5_dec_valid", bus.dec_valid, 0);
    check("t5_req_valid", bus.mem_req_valid, 0);
    check("t5_dec_pc", bus.dec_pc, 64'h0);
    tick(8);
    check("t5_late_drained", mq.size(), 0);
    check("t5_late_dropped", bus.dec_valid, 0);
    mem_lat = 1;
    bus.mem_req_ready = 1'b1;
    dmark = dlog.size();
    tick(10);
    check("t5_restart", dlog.size() > dmark, 1);
    if (dlog.size() > dmark) begin
      check("t5_pc", dlog[dmark].pc, 64'h0);
      check("t5_insn", dlog[dmark].insn, 32'h0000_0001);
    end

    // 6: HALT at 0 with no redirect
    prog.delete();
    prog[64'h0] = OP_HALT;
    pulse_reset();
    dmark = dlog.size();
    tick(10);
    s0 = stall_cycles;
    tick(100);
    check("t6_one_insn", dlog.size() - dmark, 1);
    if (dlog.size() > dmark) check("t6_insn", dlog[dmark].insn, 32'h0000_00FF);
    check("t6_redir_ready", bus.redir_ready, 1);
    check("t6_dec_valid", bus.dec_valid, 0);
    check("t6_req_valid", bus.mem_req_valid, 0);
    check("t6_stall_frozen", stall_cycles, s0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
